// File: rtl/snoopy_pkg.sv
// Shared definitions for the Snoopy sprite controllers (vertical and horizontal).
// Holds the screen geometry, the default resting row and the vertical-FSM state codes.
package snoopy_pkg;

   localparam int unsigned SCREEN_W         = 160;
   localparam int unsigned SCREEN_H         = 120;
   localparam int unsigned GROUND_Y_DEFAULT = 100;
   localparam int unsigned Y_W              = 7;

   // Vertical FSM state codes, kept as plain constants for legacy compatibility
   localparam logic [1:0] S_GROUND = 2'b00;
   localparam logic [1:0] S_RISE   = 2'b01;
   localparam logic [1:0] S_APEX   = 2'b10;
   localparam logic [1:0] S_FALL   = 2'b11;

endpackage

// File: rtl/snoopy_edge_detect.sv
// Registered rising-edge detector.
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous, active-high; clears the history register
//   level  in   level input to watch
//   rise   out  high in the cycle where level is 1 and was 0 on the previous clock
module snoopy_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic level_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) level_q <= 1'b0;
      else       level_q <= level;
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/snoopy_vertical_fsm.sv
// Vertical-motion controller for the Snoopy sprite: a jump press becomes a
// rise / apex hover / fall trajectory on snoopy_y, advancing only on move_tick.
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous, active-high
//   move_tick   in   one-cycle movement enable
//   input_jump  in   jump button level; only a 0->1 edge requests a jump
//   snoopy_y    out  current sprite row (registered)
//   airborne    out  high in every state except ground
//   landed      out  one-cycle pulse on return to ground
//   jump_count  out  jumps started, saturating at 15
module snoopy_vertical_fsm
   import snoopy_pkg::*;
#(
   parameter int unsigned GROUND_Y    = GROUND_Y_DEFAULT,
   parameter int unsigned JUMP_HEIGHT = 30,
   parameter int unsigned APEX_TICKS  = 8
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           move_tick,
   input  logic           input_jump,
   output logic [Y_W-1:0] snoopy_y,
   output logic           airborne,
   output logic           landed,
   output logic [3:0]     jump_count
);

   localparam logic [Y_W-1:0] GROUND_V  = Y_W'(GROUND_Y);
   localparam logic [Y_W-1:0] TOP_V     = Y_W'(GROUND_Y - JUMP_HEIGHT);
   localparam int unsigned    AW        = (APEX_TICKS > 1) ? $clog2(APEX_TICKS) : 1;
   localparam logic [AW-1:0]  APEX_LAST = AW'(APEX_TICKS - 1);

   logic [1:0]     state, state_nx;
   logic [Y_W-1:0] y_nx;
   logic [AW-1:0]  apex_cnt, apex_nx;
   logic           landed_nx;
   logic [3:0]     count_nx;
   logic           jump_rise;
   logic [Y_W-1:0] y_up, y_down;

   snoopy_edge_detect u_jump_edge (
      .clock (clock),
      .reset (reset),
      .level (input_jump),
      .rise  (jump_rise)
   );

   // y grows downward: rising means decrementing the row
   assign y_up   = snoopy_y - Y_W'(1);
   assign y_down = snoopy_y + Y_W'(1);

   always_comb begin
      state_nx  = state;
      y_nx      = snoopy_y;
      apex_nx   = apex_cnt;
      landed_nx = 1'b0;
      count_nx  = jump_count;
      case (state)
         S_GROUND: begin
            if (jump_rise) begin
               state_nx = S_RISE;
               if (jump_count != 4'hF) count_nx = jump_count + 4'd1;
            end
         end
         S_RISE: begin
            if (move_tick) begin
               y_nx = y_up;
               if (y_up == TOP_V) begin
                  state_nx = S_APEX;
                  apex_nx  = '0;
               end
            end
         end
         S_APEX: begin
            if (move_tick) begin
               if (apex_cnt == APEX_LAST) begin
                  state_nx = S_FALL;
                  apex_nx  = '0;
               end else begin
                  apex_nx  = apex_cnt + AW'(1);
               end
            end
         end
         default: begin
            if (move_tick) begin
               y_nx = y_down;
               if (y_down == GROUND_V) begin
                  state_nx  = S_GROUND;
                  landed_nx = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_GROUND;
         snoopy_y   <= GROUND_V;
         apex_cnt   <= '0;
         landed     <= 1'b0;
         jump_count <= '0;
      end else begin
         state      <= state_nx;
         snoopy_y   <= y_nx;
         apex_cnt   <= apex_nx;
         landed     <= landed_nx;
         jump_count <= count_nx;
      end
   end

   assign airborne = (state != S_GROUND);

endmodule

// File: tb/tb_snoopy_vertical_fsm.sv
module tb_snoopy_vertical_fsm;

   localparam int G = 100;
   localparam int H = 30;
   localparam int A = 8;

   logic       clock, reset, move_tick, input_jump;
   logic [6:0] snoopy_y;
   logic       airborne, landed;
   logic [3:0] jump_count;

   snoopy_vertical_fsm #(.GROUND_Y(G), .JUMP_HEIGHT(H), .APEX_TICKS(A)) dut (
      .clock      (clock),
      .reset      (reset),
      .move_tick  (move_tick),
      .input_jump (input_jump),
      .snoopy_y   (snoopy_y),
      .airborne   (airborne),
      .landed     (landed),
      .jump_count (jump_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Reference model: a jump is a count of ticks k since take-off; y is a
   // piecewise function of k.
   bit m_air, m_prev, m_landed;
   int m_k, m_cnt;

   // DUT-observed measurements
   int dut_ticks, landed_seen, min_y;

   function automatic int m_y();
      if (!m_air)       return G;
      if (m_k <= H)     return G - m_k;
      if (m_k <= H + A) return G - H;
      return G - H + (m_k - H - A);
   endfunction

   task automatic model_reset();
      m_air = 0; m_prev = 0; m_landed = 0; m_k = 0; m_cnt = 0;
   endtask

   task automatic model_step(input bit j, input bit t);
      bit rise;
      rise     = j & ~m_prev;
      m_prev   = j;
      m_landed = 0;
      if (!m_air) begin
         if (rise) begin
            m_air = 1;
            m_k   = 0;
            if (m_cnt < 15) m_cnt++;
         end
      end else if (t) begin
         m_k++;
         if (m_k == 2 * H + A) begin
            m_air    = 0;
            m_landed = 1;
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_all(input string tag);
      chk({tag, ".y"},        int'(snoopy_y),   m_y());
      chk({tag, ".airborne"}, int'(airborne),   int'(m_air));
      chk({tag, ".landed"},   int'(landed),     int'(m_landed));
      chk({tag, ".count"},    int'(jump_count), m_cnt);
   endtask

   // One clock: inputs are driven from the falling edge, checked 1 time unit after the rising edge
   task automatic cyc(input bit j, input bit t, input string tag);
      input_jump = j;
      move_tick  = t;
      if (airborne && t) dut_ticks++;
      @(posedge clock);
      model_step(j, t);
      #1;
      cmp_all(tag);
      if (landed) landed_seen++;
      if (int'(snoopy_y) < min_y) min_y = int'(snoopy_y);
      @(negedge clock);
   endtask

   task automatic apply_reset(input string tag);
      reset = 1'b1;
      #1;
      model_reset();
      cmp_all({tag, ".async"});
      @(posedge clock);
      #1;
      cmp_all({tag, ".held"});
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic clear_meas();
      dut_ticks = 0; landed_seen = 0; min_y = 1000;
   endtask

   task automatic run_to_ground(input bit j, input string tag);
      int i;
      i = 0;
      while (m_air && i < 400) begin
         cyc(j, 1'b1, tag);
         i++;
      end
      if (m_air) chk({tag, ".timeout"}, 1, 0);
   endtask

   typedef struct {
      bit j; bit t;
      int y; bit air; bit land; int cnt;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit j;
      reset = 1'b1; input_jump = 1'b0; move_tick = 1'b0;
      model_reset();
      clear_meas();
      #1;
      cmp_all("por");
      @(negedge clock);
      reset = 1'b0;

      // Table: edge detect, ground ignores tick, airborne edges dropped
      vecs[0] = '{0, 1, 100, 0, 0, 0};
      vecs[1] = '{1, 1, 100, 1, 0, 1};
      vecs[2] = '{1, 1,  99, 1, 0, 1};
      vecs[3] = '{0, 1,  98, 1, 0, 1};
      vecs[4] = '{1, 0,  98, 1, 0, 1};
      vecs[5] = '{0, 0,  98, 1, 0, 1};
      vecs[6] = '{0, 1,  97, 1, 0, 1};
      vecs[7] = '{1, 1,  96, 1, 0, 1};
      for (int i = 0; i < 8; i++) begin
         cyc(vecs[i].j, vecs[i].t, "vec");
         chk($sformatf("vec%0d.y", i),     int'(snoopy_y),   vecs[i].y);
         chk($sformatf("vec%0d.air", i),   int'(airborne),   int'(vecs[i].air));
         chk($sformatf("vec%0d.land", i),  int'(landed),     int'(vecs[i].land));
         chk($sformatf("vec%0d.cnt", i),   int'(jump_count), vecs[i].cnt);
      end

      // 1: reset mid-air takes effect without a clock edge
      apply_reset("t1");

      // 2: single pulse, full trajectory
      clear_meas();
      cyc(1, 1, "t2");
      cyc(0, 1, "t2");
      run_to_ground(0, "t2");
      cyc(0, 1, "t2.post");
      chk("t2.ticks", dut_ticks, 2 * H + A);
      chk("t2.landed_cycles", landed_seen, 1);
      chk("t2.min_y", min_y, G - H);
      chk("t2.count", int'(jump_count), 1);

      // 3: button held 300 cycles gives exactly one jump
      apply_reset("t3");
      clear_meas();
      for (int i = 0; i < 300; i++) cyc(1, 1, "t3");
      chk("t3.count", int'(jump_count), 1);
      chk("t3.airborne_end", int'(airborne), 0);
      chk("t3.landed_cycles", landed_seen, 1);
      cyc(0, 1, "t3.release");

      // 4: presses while rising at y=80 and during apex are dropped
      apply_reset("t4");
      clear_meas();
      cyc(1, 1, "t4");
      cyc(0, 1, "t4");
      while (m_y() != 80) cyc(0, 1, "t4.rise");
      cyc(1, 1, "t4.press80");
      cyc(0, 1, "t4");
      while (m_k < H + 3) cyc(0, 1, "t4.apex");
      cyc(1, 1, "t4.pressapex");
      cyc(0, 1, "t4");
      run_to_ground(0, "t4");
      chk("t4.ticks", dut_ticks, 2 * H + A);
      chk("t4.count", int'(jump_count), 1);
      for (int n = 0; n < 16; n++) begin
         cyc(1, 1, "t4.multi");
         cyc(0, 1, "t4.multi");
         run_to_ground(0, "t4.multi");
      end
      chk("t4.saturate", int'(jump_count), 15);

      // 5: no tick after the edge holds y; then tick every 4th cycle
      apply_reset("t5");
      cyc(1, 0, "t5");
      for (int i = 0; i < 5; i++) cyc(0, 0, "t5.hold");
      chk("t5.y_hold", int'(snoopy_y), 100);
      chk("t5.air_hold", int'(airborne), 1);
      for (int i = 0; i < 12; i++) cyc(0, (i % 4) == 3, "t5.slow");
      chk("t5.y_slow", int'(snoopy_y), 97);

      // 6: reset during fall at y=85, then a normal jump
      apply_reset("t6");
      cyc(1, 1, "t6");
      cyc(0, 1, "t6");
      while (!(m_k > H + A && m_y() == 85)) cyc(0, 1, "t6.fly");
      chk("t6.y85", int'(snoopy_y), 85);
      apply_reset("t6.mid");
      chk("t6.no_landed", int'(landed), 0);
      clear_meas();
      cyc(1, 1, "t6.again");
      cyc(0, 1, "t6.again");
      run_to_ground(0, "t6.again");
      chk("t6.ticks", dut_ticks, 2 * H + A);
      chk("t6.landed_cycles", landed_seen, 1);

      // Random stimulus against the model
      j = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            apply_reset("rnd.reset");
            j = 0;
         end else begin
            if ($urandom_range(0, 3) == 0) j = ~j;
            cyc(j, 1'($urandom_range(0, 1)), "rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
